// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin handshake arbiter.
// RR_ARB_BURST_EN selects burst-grant mode in the top level.
package rr_arb_pkg;

    localparam int N_INPUTS_DEF   = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int BURST_LEN_DEF  = 4;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// Handshake bundle: N producer channels in, one indexed channel out.
// slave = arbiter side, master = producers/consumer side.
interface rr_handshake_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N_INPUTS   = N_INPUTS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    localparam int IDX_WIDTH = clog2_min1(N_INPUTS);

    logic [N_INPUTS*DATA_WIDTH-1:0] ins;
    logic [N_INPUTS-1:0]            ins_valid;
    logic [N_INPUTS-1:0]            ins_ready;
    logic [DATA_WIDTH-1:0]          outs;
    logic [IDX_WIDTH-1:0]           outs_index;
    logic                           outs_valid;
    logic                           outs_ready;

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_index, outs_valid
    );

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_index, outs_valid
    );

endinterface

// File: rtl/rr_arb_grant.sv
// Combinational round-robin grant: first requester at or after ptr,
// wrapping at N_INPUTS-1.
module rr_arb_grant
    import rr_arb_pkg::*;
#(
    parameter int N_INPUTS = N_INPUTS_DEF,
    localparam int IW      = clog2_min1(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic [N_INPUTS-1:0] gnt_onehot,
    output logic [IW-1:0]       gnt_idx,
    output logic                any
);

    always_comb begin
        int idx;
        idx     = 0;
        any     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_INPUTS) idx -= N_INPUTS;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < N_INPUTS; i++)
            gnt_onehot[i] = any && (int'(gnt_idx) == i);
    end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin N:1 valid/ready arbiter with a registered, indexed output slot.
// Define RR_ARB_BURST_EN to allow up to BURST_LEN back-to-back grants.
module rr_handshake_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_INPUTS   = N_INPUTS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input logic clk,
    input logic rst,
    rr_handshake_arbiter_if.slave bus
);
    localparam int IW = clog2_min1(N_INPUTS);

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         g;
    logic [IW-1:0]         ptr_after_g;
    logic [N_INPUTS-1:0]   gnt_onehot;
    logic                  any;
    logic                  can_load;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] outs_q;
    logic [IW-1:0]         idx_q;
    logic                  valid_q;

    rr_arb_grant #(.N_INPUTS(N_INPUTS)) u_grant (
        .req        (bus.ins_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (g),
        .any        (any)
    );

    assign can_load    = !valid_q || bus.outs_ready;
    assign xfer        = any && can_load && !rst;
    assign ptr_after_g = (int'(g) == N_INPUTS - 1) ? '0 : g + IW'(1);

    assign bus.ins_ready  = xfer ? gnt_onehot : '0;
    assign bus.outs       = outs_q;
    assign bus.outs_index = idx_q;
    assign bus.outs_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            outs_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (xfer) begin
            outs_q  <= bus.ins[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            idx_q   <= g;
            valid_q <= 1'b1;
        end else if (bus.outs_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef RR_ARB_BURST_EN
    localparam int BW = clog2_min1(BURST_LEN + 1);
    logic [BW-1:0] bc;

    // The owner keeps priority until it has taken BURST_LEN grants in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            bc  <= '0;
        end else if (xfer) begin
            if (g == ptr && int'(bc) < BURST_LEN - 1) begin
                bc <= bc + BW'(1);
            end else begin
                ptr <= ptr_after_g;
                bc  <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (xfer)
            ptr <= ptr_after_g;
    end
`endif

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter (N=4, 32-bit data, BURST_LEN=3).
// Covers the burst schedule when RR_ARB_BURST_EN is defined.
module tb_rr_handshake_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_handshake_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(DW)) bus ();

    rr_handshake_arbiter #(
        .N_INPUTS   (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [31:0] d, input logic [1:0] ix);
        chk({tag, ".valid"}, 64'(bus.outs_valid), 64'(v));
        chk({tag, ".data"},  64'(bus.outs), 64'(d));
        chk({tag, ".index"}, 64'(bus.outs_index), 64'(ix));
    endtask

    initial begin
        rst            = 1'b1;
        bus.ins_valid  = 4'b1111;
        bus.outs_ready = 1'b1;
        for (int i = 0; i < N; i++)
            bus.ins[i*DW +: DW] = 32'h10 + 32'(i);
        #1;
        chk("rst.ready0", 64'(bus.ins_ready), 64'h0);
        tick;
        chk_out("rst.c1", 1'b0, 32'h0, 2'd0);
        chk("rst.ready1", 64'(bus.ins_ready), 64'h0);
        tick;
        chk_out("rst.c2", 1'b0, 32'h0, 2'd0);
        chk("rst.ready2", 64'(bus.ins_ready), 64'h0);
        rst = 1'b0;
        #1;
        chk("rel.ready", 64'(bus.ins_ready), 64'b0001);

`ifdef RR_ARB_BURST_EN
        begin
            int seq[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
            for (int k = 0; k < 10; k++) begin
                tick;
                chk_out($sformatf("burst[%0d]", k), 1'b1,
                        32'h10 + 32'(seq[k]), 2'(seq[k]));
            end
        end
        rst = 1'b1;
        tick;
        chk_out("burst.rst", 1'b0, 32'h0, 2'd0);
        rst = 1'b0;
        begin
            int seq2[4] = '{0, 0, 0, 1};
            for (int k = 0; k < 4; k++) begin
                tick;
                chk_out($sformatf("burst2[%0d]", k), 1'b1,
                        32'h10 + 32'(seq2[k]), 2'(seq2[k]));
            end
        end
        bus.ins_valid = 4'b1101;
        #1;
        chk("drop.ready", 64'(bus.ins_ready), 64'b0100);
        tick;
        chk_out("drop.g2", 1'b1, 32'h12, 2'd2);
        tick;
        chk_out("drop.g3", 1'b1, 32'h13, 2'd3);
`else
        for (int k = 0; k < 5; k++) begin
            tick;
            chk_out($sformatf("rot[%0d]", k), 1'b1,
                    32'h10 + 32'(k % 4), 2'(k % 4));
        end

        bus.outs_ready = 1'b0;
        #1;
        chk("bp.ready", 64'(bus.ins_ready), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk_out($sformatf("bp[%0d]", k), 1'b1, 32'h10, 2'd0);
            chk($sformatf("bp.ready[%0d]", k), 64'(bus.ins_ready), 64'h0);
        end
        bus.outs_ready = 1'b1;
        #1;
        chk("bp.rel.ready", 64'(bus.ins_ready), 64'b0010);
        tick;
        chk_out("bp.refill", 1'b1, 32'h11, 2'd1);

        bus.ins_valid = 4'b1010;
        #1;
        chk("skip.ready", 64'(bus.ins_ready), 64'b1000);
        begin
            logic [1:0] sk[4] = '{2'd3, 2'd1, 2'd3, 2'd1};
            for (int k = 0; k < 4; k++) begin
                tick;
                chk_out($sformatf("skip[%0d]", k), 1'b1,
                        32'h10 + 32'(sk[k]), sk[k]);
            end
        end

        bus.ins_valid = 4'b0000;
        tick;
        chk_out("drain", 1'b0, 32'h11, 2'd1);

        bus.ins_valid = 4'b1111;
        tick;
        chk_out("pre.rst", 1'b1, 32'h12, 2'd2);
        rst = 1'b1;
        #1;
        chk("mid.rst.ready", 64'(bus.ins_ready), 64'h0);
        tick;
        chk_out("mid.rst", 1'b0, 32'h0, 2'd0);
        rst = 1'b0;
        #1;
        chk("mid.rel.ready", 64'(bus.ins_ready), 64'b0001);
        tick;
        chk_out("mid.first", 1'b1, 32'h10, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
